bus_ctrl: RTL and testbench

Single-outstanding memory-bus controller that sits between the core's load/store port and the memory-mapped devices. It registers one request and presents it to the `decode` block. It then routes the transaction to the device `decode` selects, waits for that device's acknowledge, and returns read data or an error to the core. It is the consumer of `decode`'s `hit`/`did` outputs and the only driver of its `rd`/`wr`/`addr` inputs.

---
 rtl/bus_ctrl.sv | 172 +++++++++++++++++
 tb/tb_bus_ctrl.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_ctrl.sv
// -----------------------------------------------------------------------------
// bus_ctrl
//
// Single-outstanding memory-bus controller between the core load/store port
// and the memory-mapped devices. One request is registered and shown to the
// external address decoder. The transaction is then steered to the device
// the decoder names, and the controller waits for that device's acknowledge
// (bounded by TIMEOUT cycles). Finally it returns read data or an error to
// the core as a one-cycle response pulse.
//
// Parameters
//   TIMEOUT    maximum ACCESS cycles to wait for an acknowledge (1..255)
//
// Ports
//   clk, rst_n        system clock (rising edge), async active-low reset
//   req_valid/ready   core request handshake
//   req_wr            1 = write, 0 = read
//   req_addr          16-bit byte address
//   req_wdata         16-bit write data
//   dec_rd/wr/addr    request presented to the address decoder
//   dec_hit/did       decoder result (did 7 means "no device")
//   dev_sel           one-hot device select, bit n = device n
//   dev_rd/wr         read/write strobe to the selected device
//   dev_addr          offset inside the device window (addr[11:0])
//   dev_wdata         write data to the device
//   dev_rdata         packed read data, device n on bits [16n+15:16n]
//   dev_ack           per-device completion, bit n = device n
//   rsp_valid         one-cycle response pulse
//   rsp_rdata         read data (0 for writes and errors)
//   rsp_err           decode miss or timeout
// -----------------------------------------------------------------------------
module bus_ctrl #(
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_wr,
    input  logic [15:0]   req_addr,
    input  logic [15:0]   req_wdata,
    output logic          dec_rd,
    output logic          dec_wr,
    output logic [15:0]   dec_addr,
    input  logic          dec_hit,
    input  logic [2:0]    dec_did,
    output logic [6:0]    dev_sel,
    output logic          dev_rd,
    output logic          dev_wr,
    output logic [11:0]   dev_addr,
    output logic [15:0]   dev_wdata,
    input  logic [111:0]  dev_rdata,
    input  logic [6:0]    dev_ack,
    output logic          rsp_valid,
    output logic [15:0]   rsp_rdata,
    output logic          rsp_err
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DECODE = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] RESP   = 2'd3;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);
    localparam logic [2:0] DID_NONE    = 3'd7;

    logic [1:0]  state;
    logic        wr_q;
    logic [15:0] addr_q;
    logic [15:0] wdata_q;
    logic [2:0]  did_q;
    logic [7:0]  cnt_q;
    logic        err_q;
    logic [15:0] rdata_q;

    logic        ack_hit;
    logic [7:0]  cnt_next;
    logic [15:0] rdata_slice;
    logic [7:0]  ack_ext;

    // Only the acknowledge of the device we actually selected counts; the
    // vector is widened so that every did_q value indexes a real bit.
    assign ack_ext  = {1'b0, dev_ack};
    assign ack_hit  = ack_ext[did_q];
    assign cnt_next = cnt_q + 8'd1;

    // Pick the 16-bit read-data lane of the selected device.
    always_comb begin
        rdata_slice = 16'd0;
        for (int i = 0; i < 7; i++) begin
            if (did_q == 3'(i)) begin
                rdata_slice = dev_rdata[i*16 +: 16];
            end
        end
    end

    // Transaction sequencer. A request is accepted only in IDLE; every other
    // state ignores req_valid. The response register pair (rdata_q/err_q)
    // is cleared on acceptance so a decode miss or a write naturally returns
    // zero data. An acknowledge on the last allowed ACCESS cycle wins over
    // the timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            wr_q    <= 1'b0;
            addr_q  <= 16'd0;
            wdata_q <= 16'd0;
            did_q   <= 3'd0;
            cnt_q   <= 8'd0;
            err_q   <= 1'b0;
            rdata_q <= 16'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        wr_q    <= req_wr;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        err_q   <= 1'b0;
                        rdata_q <= 16'd0;
                        state   <= DECODE;
                    end
                end
                DECODE: begin
                    if (dec_hit && (dec_did != DID_NONE)) begin
                        did_q <= dec_did;
                        cnt_q <= 8'd0;
                        state <= ACCESS;
                    end else begin
                        err_q <= 1'b1;
                        state <= RESP;
                    end
                end
                ACCESS: begin
                    if (ack_hit) begin
                        rdata_q <= wr_q ? 16'd0 : rdata_slice;
                        err_q   <= 1'b0;
                        state   <= RESP;
                    end else begin
                        cnt_q <= cnt_next;
                        if (cnt_next == TIMEOUT_CNT) begin
                            rdata_q <= 16'd0;
                            err_q   <= 1'b1;
                            state   <= RESP;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // All outputs decode directly from the state and the request registers,
    // so an asynchronous reset drops every strobe without waiting for a clock.
    always_comb begin
        req_ready = (state == IDLE);
        dec_rd    = (state == DECODE) && !wr_q;
        dec_wr    = (state == DECODE) && wr_q;
        dec_addr  = addr_q;
        dev_sel   = (state == ACCESS) ? (7'd1 << did_q) : 7'd0;
        dev_rd    = (state == ACCESS) && !wr_q;
        dev_wr    = (state == ACCESS) && wr_q;
        dev_addr  = addr_q[11:0];
        dev_wdata = wdata_q;
        rsp_valid = (state == RESP);
        rsp_rdata = (state == RESP) ? rdata_q : 16'd0;
        rsp_err   = (state == RESP) && err_q;
    end

endmodule

// File: tb/tb_bus_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bus_ctrl
//
// Self-checking bench for bus_ctrl. It plays the roles of the address decoder
// (window n = addr[15:12] for n < 7, otherwise a miss), the seven devices
// (programmable acknowledge delay, spurious acknowledges on other lines), and
// the core. Expected results come from a transaction-level model of the
// controller's rules: latency, number of device-access cycles, error and
// returned data.
// -----------------------------------------------------------------------------
module tb_bus_ctrl;

    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_wr = 1'b0;
    logic [15:0]   req_addr = 16'd0;
    logic [15:0]   req_wdata = 16'd0;
    logic          dec_rd, dec_wr;
    logic [15:0]   dec_addr;
    logic          dec_hit;
    logic [2:0]    dec_did;
    logic [6:0]    dev_sel;
    logic          dev_rd, dev_wr;
    logic [11:0]   dev_addr;
    logic [15:0]   dev_wdata;
    logic [111:0]  dev_rdata = '0;
    logic [6:0]    dev_ack = 7'd0;
    logic          rsp_valid;
    logic [15:0]   rsp_rdata;
    logic          rsp_err;

    int checks = 0;
    int errors = 0;

    bus_ctrl #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .dec_rd(dec_rd), .dec_wr(dec_wr), .dec_addr(dec_addr),
        .dec_hit(dec_hit), .dec_did(dec_did),
        .dev_sel(dev_sel), .dev_rd(dev_rd), .dev_wr(dev_wr),
        .dev_addr(dev_addr), .dev_wdata(dev_wdata), .dev_rdata(dev_rdata),
        .dev_ack(dev_ack),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Decoder stand-in: 4 KB windows, window 7 and above miss. force_did7
    // models a decoder reporting a hit with the "none" device id.
    logic force_did7 = 1'b0;
    always_comb begin
        dec_hit = 1'b0;
        dec_did = 3'd7;
        if (dec_rd || dec_wr) begin
            if (force_did7) begin
                dec_hit = 1'b1;
                dec_did = 3'd7;
            end else if (dec_addr[15:12] < 4'd7) begin
                dec_hit = 1'b1;
                dec_did = dec_addr[14:12];
            end
        end
    end

    // Device stand-in: the selected device acks after ack_delay wait cycles
    // (-1 = never). Other lines carry spur_busy while selected, spur_idle
    // otherwise.
    int          ack_delay = -1;
    logic [6:0]  spur_busy = 7'd0;
    logic [6:0]  spur_idle = 7'd0;
    int          acc_k = 0;
    logic [15:0] words [7];

    always @(negedge clk) begin
        if (dev_sel != 7'd0) begin
            dev_ack = spur_busy;
            if (acc_k == ack_delay) dev_ack = dev_ack | dev_sel;
            acc_k++;
        end else begin
            dev_ack = spur_idle;
            acc_k = 0;
        end
    end

    // Observer of the device and decoder sides; totals are only ever read
    // as deltas around a transaction.
    int          mon_acc = 0, mon_dec = 0, mon_unst = 0;
    logic        prev_active = 1'b0;
    logic [6:0]  mon_sel = 7'd0;
    logic        mon_rd = 1'b0, mon_wr = 1'b0;
    logic [11:0] mon_daddr = 12'd0;
    logic [15:0] mon_dwdata = 16'd0;
    logic        mon_dec_rd = 1'b0, mon_dec_wr = 1'b0;
    logic [15:0] mon_dec_addr = 16'd0;

    always @(negedge clk) begin
        if (dev_sel != 7'd0) begin
            if (!prev_active) begin
                mon_sel = dev_sel; mon_rd = dev_rd; mon_wr = dev_wr;
                mon_daddr = dev_addr; mon_dwdata = dev_wdata;
            end else if ({dev_sel, dev_rd, dev_wr, dev_addr, dev_wdata} !==
                         {mon_sel, mon_rd, mon_wr, mon_daddr, mon_dwdata}) begin
                mon_unst++;
            end
            mon_acc++;
            prev_active = 1'b1;
        end else begin
            prev_active = 1'b0;
        end
        if (dec_rd || dec_wr) begin
            mon_dec++;
            mon_dec_rd = dec_rd; mon_dec_wr = dec_wr; mon_dec_addr = dec_addr;
        end
    end

    task automatic load_words();
        for (int i = 0; i < 7; i++) begin
            words[i] = 16'($urandom);
            dev_rdata[i*16 +: 16] = words[i];
        end
    endtask

    task automatic set_word(input int idx, input logic [15:0] val);
        words[idx] = val;
        dev_rdata[idx*16 +: 16] = val;
    endtask

    // Transaction-level model: which device, how long, what comes back.
    task automatic model(input logic [15:0] addr, input logic wr, input int delay,
                         input bit f7, output logic err, output logic [15:0] rdata,
                         output int lat, output int acc, output int did);
        int window;
        window = int'(addr[15:12]);
        if (f7 || window >= 7) begin
            err = 1'b1; rdata = 16'd0; lat = 2; acc = 0; did = -1;
        end else begin
            did = window;
            if (delay >= 0 && delay < TO) begin
                err = 1'b0; rdata = wr ? 16'd0 : words[did];
                lat = 3 + delay; acc = delay + 1;
            end else begin
                err = 1'b1; rdata = 16'd0; lat = 2 + TO; acc = TO;
            end
        end
    endtask

    // Core stand-in. Called just after a falling edge. Presents the request,
    // waits for acceptance, then scribbles on the request bus while busy
    // (keeping req_valid high when hold is set) and returns at the falling
    // edge of the response cycle. lat counts cycles after the accepting edge.
    task automatic run_txn(input logic [15:0] addr, input logic wr,
                           input logic [15:0] wdata, input bit hold,
                           output int waits, output int lat,
                           output logic [15:0] rdata, output logic err,
                           output int acc, output int decn, output int unst);
        int acc0, dec0, unst0;
        acc0 = mon_acc; dec0 = mon_dec; unst0 = mon_unst;
        req_valid = 1'b1; req_wr = wr; req_addr = addr; req_wdata = wdata;
        waits = 0;
        while (!req_ready && waits < 50) begin
            @(posedge clk); @(negedge clk); waits++;
        end
        @(posedge clk);
        lat = 0; rdata = 'x; err = 1'bx;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (!hold) req_valid = 1'b0;
            req_addr = 16'($urandom); req_wr = 1'($urandom); req_wdata = 16'($urandom);
            if (rsp_valid) begin
                lat = k; rdata = rsp_rdata; err = rsp_err;
                break;
            end
            @(posedge clk);
        end
        acc = mon_acc - acc0; decn = mon_dec - dec0; unst = mon_unst - unst0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 1", req_ready); end
        checks++; if (dev_sel !== 7'd0) begin errors++; $display("[TB] FAIL reset_sel: got %b expected 0", dev_sel); end
        checks++; if ({rsp_valid, rsp_err, rsp_rdata} !== 18'd0) begin errors++; $display("[TB] FAIL reset_rsp: got %b/%b/%h expected 0", rsp_valid, rsp_err, rsp_rdata); end
        checks++; if ({dev_rd, dev_wr, dec_rd, dec_wr} !== 4'd0) begin errors++; $display("[TB] FAIL reset_strobes: got %b expected 0000", {dev_rd, dev_wr, dec_rd, dec_wr}); end
        checks++; if ({dec_addr, dev_addr, dev_wdata} !== 44'd0) begin errors++; $display("[TB] FAIL reset_addr: got %h/%h/%h expected 0", dec_addr, dev_addr, dev_wdata); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_ready: got %b expected 1", req_ready); end
    endtask

    task automatic test_read_drom();
        int w, lat, acc, decn, unst;
        logic [15:0] rd;
        logic er;
        load_words(); set_word(1, 16'h55AA);
        ack_delay = 0; spur_busy = 7'd0; spur_idle = 7'd0;
        run_txn(16'h1ABC, 1'b0, 16'h0000, 1'b0, w, lat, rd, er, acc, decn, unst);
        checks++; if ({mon_dec_rd, mon_dec_wr} !== 2'b10 || decn !== 1) begin errors++; $display("[TB] FAIL drom_dec_rd: got rd%b wr%b n%0d expected rd1 wr0 n1", mon_dec_rd, mon_dec_wr, decn); end
        checks++; if (mon_dec_addr !== 16'h1ABC) begin errors++; $display("[TB] FAIL drom_dec_addr: got %h expected 1abc", mon_dec_addr); end
        checks++; if (mon_sel !== 7'b0000010 || acc !== 1) begin errors++; $display("[TB] FAIL drom_sel: got %b x%0d expected 0000010 x1", mon_sel, acc); end
        checks++; if (mon_daddr !== 12'hABC || mon_rd !== 1'b1) begin errors++; $display("[TB] FAIL drom_dev_addr: got %h rd%b expected abc rd1", mon_daddr, mon_rd); end
        checks++; if (lat !== 3) begin errors++; $display("[TB] FAIL drom_latency: got %0d expected 3", lat); end
        checks++; if (rd !== 16'h55AA || er !== 1'b0) begin errors++; $display("[TB] FAIL drom_rsp: got %h err%b expected 55aa err0", rd, er); end
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("[TB] FAIL drom_after: got valid%b ready%b expected valid0 ready1", rsp_valid, req_ready); end
    endtask

    task automatic test_write_dspi();
        int w, lat, acc, decn, unst;
        logic [15:0] rd;
        logic er;
        load_words();
        ack_delay = 3;
        run_txn(16'h6FFF, 1'b1, 16'hBEEF, 1'b0, w, lat, rd, er, acc, decn, unst);
        checks++; if (mon_dec_wr !== 1'b1 || mon_dec_rd !== 1'b0) begin errors++; $display("[TB] FAIL dspi_dec_wr: got wr%b rd%b expected wr1 rd0", mon_dec_wr, mon_dec_rd); end
        checks++; if (mon_sel !== 7'b1000000 || mon_wr !== 1'b1 || mon_rd !== 1'b0) begin errors++; $display("[TB] FAIL dspi_sel: got %b wr%b rd%b expected 1000000 wr1 rd0", mon_sel, mon_wr, mon_rd); end
        checks++; if (acc !== 4 || unst !== 0) begin errors++; $display("[TB] FAIL dspi_hold: got %0d cycles %0d changes expected 4 cycles 0 changes", acc, unst); end
        checks++; if (mon_dwdata !== 16'hBEEF || mon_daddr !== 12'hFFF) begin errors++; $display("[TB] FAIL dspi_data: got %h@%h expected beef@fff", mon_dwdata, mon_daddr); end
        checks++; if (rd !== 16'h0000 || er !== 1'b0 || lat !== 6) begin errors++; $display("[TB] FAIL dspi_rsp: got %h err%b lat%0d expected 0000 err0 lat6", rd, er, lat); end
    endtask

    task automatic test_miss();
        int w, lat, acc, decn, unst;
        logic [15:0] rd;
        logic er;
        ack_delay = 0;
        run_txn(16'h7000, 1'b0, 16'h0000, 1'b0, w, lat, rd, er, acc, decn, unst);
        checks++; if (acc !== 0) begin errors++; $display("[TB] FAIL miss_no_sel: got %0d cycles expected 0", acc); end
        checks++; if (lat !== 2 || er !== 1'b1 || rd !== 16'd0) begin errors++; $display("[TB] FAIL miss_rsp: got lat%0d err%b %h expected lat2 err1 0000", lat, er, rd); end
        force_did7 = 1'b1;
        run_txn(16'h2000, 1'b0, 16'h0000, 1'b0, w, lat, rd, er, acc, decn, unst);
        force_did7 = 1'b0;
        checks++; if (acc !== 0 || lat !== 2 || er !== 1'b1 || rd !== 16'd0) begin errors++; $display("[TB] FAIL did7_rsp: got acc%0d lat%0d err%b %h expected acc0 lat2 err1 0000", acc, lat, er, rd); end
    endtask

    task automatic test_timeout();
        int w, lat, acc, decn, unst;
        logic [15:0] rd;
        logic er;
        load_words();
        ack_delay = -1; spur_busy = 7'b0001000;
        run_txn(16'h0000, 1'b0, 16'h0000, 1'b0, w, lat, rd, er, acc, decn, unst);
        spur_busy = 7'd0;
        checks++; if (acc !== TO || mon_sel !== 7'b0000001) begin errors++; $display("[TB] FAIL timeout_cycles: got %0d sel %b expected %0d sel 0000001", acc, mon_sel, TO); end
        checks++; if (er !== 1'b1 || rd !== 16'd0 || lat !== 2 + TO) begin errors++; $display("[TB] FAIL timeout_rsp: got err%b %h lat%0d expected err1 0000 lat%0d", er, rd, lat, 2 + TO); end
        ack_delay = TO - 1;
        run_txn(16'h3010, 1'b0, 16'h0000, 1'b0, w, lat, rd, er, acc, decn, unst);
        checks++; if (er !== 1'b0 || rd !== words[3] || lat !== 2 + TO) begin errors++; $display("[TB] FAIL ack_at_limit: got err%b %h lat%0d expected err0 %h lat%0d", er, rd, lat, words[3], 2 + TO); end
        ack_delay = TO;
        run_txn(16'h3010, 1'b0, 16'h0000, 1'b0, w, lat, rd, er, acc, decn, unst);
        checks++; if (er !== 1'b1 || acc !== TO) begin errors++; $display("[TB] FAIL ack_after_limit: got err%b acc%0d expected err1 acc%0d", er, acc, TO); end
    endtask

    task automatic test_back_to_back();
        int w, lat, acc, decn, unst;
        logic [15:0] rd;
        logic er;
        load_words();
        ack_delay = 1;
        run_txn(16'h4444, 1'b0, 16'h0000, 1'b1, w, lat, rd, er, acc, decn, unst);
        checks++; if (rd !== words[4] || er !== 1'b0 || lat !== 4) begin errors++; $display("[TB] FAIL b2b_first: got %h err%b lat%0d expected %h err0 lat4", rd, er, lat, words[4]); end
        run_txn(16'h5A5A, 1'b1, 16'h1234, 1'b0, w, lat, rd, er, acc, decn, unst);
        checks++; if (w !== 1) begin errors++; $display("[TB] FAIL b2b_accept: got %0d waits expected 1", w); end
        checks++; if (mon_dec_addr !== 16'h5A5A || mon_sel !== 7'b0100000 || mon_daddr !== 12'hA5A) begin errors++; $display("[TB] FAIL b2b_addr: got %h sel %b off %h expected 5a5a sel 0100000 off a5a", mon_dec_addr, mon_sel, mon_daddr); end
        checks++; if (rd !== 16'd0 || er !== 1'b0 || lat !== 4 || mon_dwdata !== 16'h1234) begin errors++; $display("[TB] FAIL b2b_second: got %h err%b lat%0d wdata %h expected 0000 err0 lat4 wdata 1234", rd, er, lat, mon_dwdata); end
    endtask

    task automatic test_random();
        int w, lat, acc, decn, unst, e_lat, e_acc, e_did;
        logic [15:0] rd, e_rd, addr, wd;
        logic er, e_err, wr;
        bit hold;
        for (int n = 0; n < 40; n++) begin
            load_words();
            addr = {4'($urandom_range(0, 9)), 12'($urandom)};
            wr = 1'($urandom); wd = 16'($urandom); hold = 1'($urandom);
            ack_delay = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 5));
            force_did7 = ($urandom_range(0, 9) == 0);
            spur_idle = 7'($urandom);
            model(addr, wr, ack_delay, force_did7, e_err, e_rd, e_lat, e_acc, e_did);
            spur_busy = 7'($urandom);
            if (e_did >= 0) spur_busy[e_did] = 1'b0;
            run_txn(addr, wr, wd, hold, w, lat, rd, er, acc, decn, unst);
            checks++; if (lat !== e_lat || acc !== e_acc) begin errors++; $display("[TB] FAIL rand_timing #%0d: got lat%0d acc%0d expected lat%0d acc%0d", n, lat, acc, e_lat, e_acc); end
            checks++; if (er !== e_err || rd !== e_rd) begin errors++; $display("[TB] FAIL rand_rsp #%0d: got err%b %h expected err%b %h", n, er, rd, e_err, e_rd); end
            checks++; if (decn !== 1 || mon_dec_addr !== addr || mon_dec_wr !== wr) begin errors++; $display("[TB] FAIL rand_dec #%0d: got n%0d %h wr%b expected n1 %h wr%b", n, decn, mon_dec_addr, mon_dec_wr, addr, wr); end
            if (e_did >= 0) begin
                checks++; if (mon_sel !== 7'(1 << e_did) || mon_daddr !== addr[11:0] || mon_wr !== wr || mon_rd !== !wr || unst !== 0) begin errors++; $display("[TB] FAIL rand_dev #%0d: got sel %b off %h wr%b rd%b chg%0d expected sel %b off %h wr%b rd%b chg0", n, mon_sel, mon_daddr, mon_wr, mon_rd, unst, 7'(1 << e_did), addr[11:0], wr, !wr); end
                if (wr) begin
                    checks++; if (mon_dwdata !== wd) begin errors++; $display("[TB] FAIL rand_wdata #%0d: got %h expected %h", n, mon_dwdata, wd); end
                end
            end
        end
        force_did7 = 1'b0; spur_busy = 7'd0; spur_idle = 7'd0;
        req_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_access();
        int seen;
        ack_delay = -1;
        req_valid = 1'b1; req_wr = 1'b0; req_addr = 16'h0123;
        @(posedge clk);
        @(negedge clk); req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (dev_rd !== 1'b1 || dev_sel !== 7'b0000001) begin errors++; $display("[TB] FAIL abort_pre: got rd%b sel %b expected rd1 sel 0000001", dev_rd, dev_sel); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (dev_rd !== 1'b0 || dev_sel !== 7'd0) begin errors++; $display("[TB] FAIL abort_async: got rd%b sel %b expected rd0 sel 0", dev_rd, dev_sel); end
        seen = 0;
        repeat (2) begin @(negedge clk); if (rsp_valid) seen++; end
        rst_n = 1'b1;
        repeat (8) begin @(negedge clk); if (rsp_valid) seen++; end
        checks++; if (seen !== 0 || req_ready !== 1'b1) begin errors++; $display("[TB] FAIL abort_rsp: got %0d pulses ready%b expected 0 pulses ready1", seen, req_ready); end
    endtask

    initial begin
        test_reset();
        test_read_drom();
        test_write_dspi();
        test_miss();
        test_timeout();
        test_back_to_back();
        test_random();
        test_reset_mid_access();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
